// File: rtl/fp_div_seq.sv
// Sequential IEEE754 single-precision divider: restoring mantissa division, one quotient bit per cycle.
// Special operands resolve in one cycle; denormals flush to zero and the quotient is truncated.
module fp_div_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] out
);
    typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [25:0] rem_q, rem_d;
    logic [24:0] quo_q, quo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] res_q, res_d;
    logic [31:0] out_q, out_d;
    logic        done_q, done_d;

    // Operand classification happens on the inputs so specials finish on the accept edge.
    logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sgn_in;
    logic        spec_hit;
    logic [31:0] spec_res;

    assign a_zero = (in1[30:23] == 8'h00);
    assign a_inf  = (in1[30:23] == 8'hFF) && (in1[22:0] == 23'd0);
    assign a_nan  = (in1[30:23] == 8'hFF) && (in1[22:0] != 23'd0);
    assign b_zero = (in2[30:23] == 8'h00);
    assign b_inf  = (in2[30:23] == 8'hFF) && (in2[22:0] == 23'd0);
    assign b_nan  = (in2[30:23] == 8'hFF) && (in2[22:0] != 23'd0);
    assign sgn_in = in1[31] ^ in2[31];

    always_comb begin
        spec_hit = 1'b1;
        spec_res = QNAN;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
            spec_res = QNAN;
        else if (a_inf || b_zero)
            spec_res = {sgn_in, 8'hFF, 23'd0};
        else if (a_zero || b_inf)
            spec_res = {sgn_in, 31'd0};
        else
            spec_hit = 1'b0;
    end

    // Remainder stays below 2*divisor < 2^25, so bit 25 of the trial difference is a clean borrow.
    logic [25:0] trial;
    assign trial = rem_q - {2'b00, 1'b1, b_q[22:0]};

    logic signed [9:0] exp_s;
    logic [22:0]       frac;
    assign exp_s = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]})
                 + (quo_q[24] ? 10'sd127 : 10'sd126);
    assign frac  = quo_q[24] ? quo_q[23:1] : quo_q[22:0];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                a_d = in1;
                b_d = in2;
                if (spec_hit) begin
                    res_d   = spec_res;
                    state_d = DONE;
                end else begin
                    rem_d   = {3'b001, in1[22:0]};
                    quo_d   = 25'd0;
                    cnt_d   = 5'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                quo_d = {quo_q[23:0], ~trial[25]};
                rem_d = trial[25] ? {rem_q[24:0], 1'b0} : {trial[24:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd24) state_d = NORM;
            end
            NORM: begin
                if (exp_s >= 10'sd255)
                    res_d = {a_q[31] ^ b_q[31], 8'hFF, 23'd0};
                else if (exp_s <= 10'sd0)
                    res_d = {a_q[31] ^ b_q[31], 31'd0};
                else
                    res_d = {a_q[31] ^ b_q[31], exp_s[7:0], frac};
                state_d = DONE;
            end
            DONE: begin
                out_d   = res_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            rem_q   <= 26'd0;
            quo_q   <= 25'd0;
            cnt_q   <= 5'd0;
            res_q   <= 32'd0;
            out_q   <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign out  = out_q;
endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq: stimulus pushes expected result and latency, a monitor pops on done.
module tb_fp_div_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] in1 = 32'd0;
    logic [31:0] in2 = 32'd0;
    logic        busy, done;
    logic [31:0] out;

    fp_div_seq dut (
        .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2),
        .start(start), .busy(busy), .done(done), .out(out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got out=%h expected no done", out);
            end else begin
                e = sb.pop_front();
                chk("result", out, e.res);
                chk("latency", cyc - e.acc, e.lat);
            end
        end
    end

    // Returns just after the accept edge (+1 time unit).
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input int lat);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: got busy=%b expected 0", busy);
        end
        @(negedge clk);
        in1 = a;
        in2 = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back('{r, cyc, lat});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    int dc0;

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_out", out, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 6/2 with busy/done timing around the 27-edge latency
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 27);
        for (int k = 1; k <= 27; k++) begin
            @(posedge clk);
            #1;
            if (k == 1 || k == 26) chk("busy_high", {31'd0, busy}, 32'd1);
            if (k == 26) chk("no_early_done", {31'd0, done}, 32'd0);
            if (k == 27) begin
                chk("busy_low", {31'd0, busy}, 32'd0);
                chk("done_pulse", {31'd0, done}, 32'd1);
            end
        end
        drain();

        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 27); // 1/3 truncated
        issue(32'hC0C00000, 32'h40000000, 32'hC0400000, 27); // -6/2
        issue(32'h3F800000, 32'h00000000, 32'h7F800000, 1);  // 1/0
        issue(32'hBF800000, 32'h00000000, 32'hFF800000, 1);  // -1/0
        issue(32'h00000000, 32'h00000000, 32'h7FC00000, 1);  // 0/0
        issue(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1);  // NaN/1
        issue(32'h7F800000, 32'hFF800000, 32'h7FC00000, 1);  // inf/-inf
        issue(32'hFF800000, 32'h40000000, 32'hFF800000, 1);  // -inf/2
        issue(32'h40000000, 32'h7F800000, 32'h00000000, 1);  // 2/inf
        issue(32'h00000000, 32'hC0000000, 32'h80000000, 1);  // 0/-2
        issue(32'h00000001, 32'h3F800000, 32'h00000000, 1);  // denormal/1
        issue(32'h3F800000, 32'h00000001, 32'h7F800000, 1);  // 1/denormal
        issue(32'h7F000000, 32'h3E800000, 32'h7F800000, 27); // overflow
        issue(32'h00800000, 32'h7F000000, 32'h00000000, 27); // underflow
        issue(32'h3F800000, 32'h3F800000, 32'h3F800000, 27); // 1/1
        drain();

        // start while busy must be ignored
        dc0 = done_cnt;
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 27);
        repeat (4) @(posedge clk);
        @(negedge clk);
        in1 = 32'h3F800000;
        in2 = 32'h00000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        repeat (5) @(negedge clk);
        chk("single_done", done_cnt - dc0, 32'd1);

        // reset mid-CALC aborts without done
        dc0 = done_cnt;
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 27);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_out", out, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_no_done", done_cnt - dc0, 32'd0);
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 27);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
